uart_tx_sequencer: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_sequencer_if.sv | 12 +
 rtl/uart_tx_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default oversampling and data-width limits.
// Used by both the transmit and receive sequencers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int UART_OVERSAMPLE_DEF = 16;
    localparam int UART_DATA_BITS_MIN  = 5;
    localparam int UART_DATA_BITS_MAX  = 8;

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Byte-stream handshake between the host-side byte source and the UART transmitter.
// Valid/ready: a byte transfers on the rising edge where tx_valid and tx_ready are both high; the source holds tx_data stable until then.
interface uart_tx_sequencer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: counts shared oversampling ticks to frame a byte as
// start bit, LSB-first data, optional parity and stop bits on a registered tx line.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    uart_tx_sequencer_if.slave  s_if,
    output logic                tx,
    output logic                busy,
    output logic                tx_done,
    output uart_state_e         state_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end = tick && (tick_cnt_q == LAST_TICK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        done_d     = 1'b0;
        tx_d       = 1'b1;

        // Ticks only advance the bit timer while a frame is in flight.
        if (state_q != IDLE && tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (s_if.tx_valid) begin
                    state_d    = START;
                    shift_d    = s_if.tx_data;
                    parity_d   = (^s_if.tx_data) ^ (PARITY_ODD != 0);
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // The bit counter is reused to count stop-bit periods.
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign s_if.tx_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign tx            = tx_q;
    assign tx_done       = done_q;
    assign state_o       = state_q;

endmodule
